// File: rtl/stmn_frame_gen_pkg.sv
// stmn_frame_gen_pkg: STM-N framing constants, J0 trace message and overhead byte map
package stmn_frame_gen_pkg;
  localparam int STMN_COLS_PER_N = 270;
  localparam int OH_COLS_PER_N = 9;
  localparam logic [7:0] A1_BYTE = 8'hF6;
  localparam logic [7:0] A2_BYTE = 8'h28;
  localparam logic [7:0] H1_FIRST = 8'h68;
  localparam logic [7:0] H1_CONCAT = 8'h93;
  localparam logic [7:0] H2_FIRST = 8'h00;
  localparam logic [7:0] H2_CONCAT = 8'hFF;
  localparam logic [7:0] LETTER_P = 8'h50;
  localparam logic [7:0] LETTER_A = 8'h41;
  localparam logic [7:0] LETTER_R = 8'h52;
  localparam logic [7:0] LETTER_M = 8'h4D;
  localparam logic [7:0] LETTER_N = 8'h4E;
  localparam logic [7:0] SPACE_LETTER = 8'h20;
  localparam logic [7:0] TRACE_MSG [16] = '{
    LETTER_P, LETTER_A, LETTER_R, LETTER_M, LETTER_A, LETTER_N,
    SPACE_LETTER, SPACE_LETTER, SPACE_LETTER, SPACE_LETTER, SPACE_LETTER,
    SPACE_LETTER, SPACE_LETTER, SPACE_LETTER, SPACE_LETTER, SPACE_LETTER};
  typedef struct packed {
    logic [3:0] row;
    logic [12:0] col;
  } stm_pos_t;
  function automatic logic [7:0] oh_byte(input logic [3:0] row, input logic [12:0] col,
                                         input logic [12:0] n, input logic [7:0] j0,
                                         input logic [7:0] b1);
    logic [12:0] n3, n6;
    n3 = n + n + n;
    n6 = n3 + n3;
    oh_byte = 8'h00;
    if (row == 4'd0)
      oh_byte = col < n3 ? A1_BYTE : col < n6 ? A2_BYTE : col == n6 ? j0 : 8'h00;
    else if (row == 4'd1)
      oh_byte = col == 13'd0 ? b1 : 8'h00;
    else if (row == 4'd3)
      oh_byte = col == 13'd0 ? H1_FIRST : col < n ? H1_CONCAT :
                col == n3 ? H2_FIRST : (col > n3 && col < n3 + n) ? H2_CONCAT : 8'h00;
  endfunction
endpackage

// File: rtl/stmn_frame_gen_pos_cnt.sv
// stmn_pos_cnt: row/col position, frame counter and J0 trace index for the STM-N framer
module stmn_pos_cnt
  import stmn_frame_gen_pkg::*;
#(
  parameter int STM_N = 1,
  parameter int TRACE_LEN = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic advance,
  output stm_pos_t nxt,
  output logic nxt_payload,
  output logic wrap,
  output logic [15:0] frame_cnt,
  output logic [3:0] trace_idx
);
  localparam logic [12:0] LAST_COL = 13'(STMN_COLS_PER_N * STM_N - 1);
  localparam logic [12:0] OH_COLS = 13'(OH_COLS_PER_N * STM_N);
  localparam logic [3:0] LAST_TRACE = 4'(TRACE_LEN - 1);
  stm_pos_t pos;
  logic col_end;
  always_comb begin
    col_end = pos.col == LAST_COL;
    wrap = col_end && pos.row == 4'd8;
    nxt.col = col_end ? 13'd0 : pos.col + 13'd1;
    nxt.row = wrap ? 4'd0 : col_end ? pos.row + 4'd1 : pos.row;
    nxt_payload = nxt.col >= OH_COLS;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pos <= '0;
      frame_cnt <= '0;
      trace_idx <= '0;
    end else if (advance) begin
      pos <= nxt;
      if (wrap) begin
        frame_cnt <= frame_cnt + 16'd1;
        trace_idx <= trace_idx == LAST_TRACE ? 4'd0 : trace_idx + 4'd1;
      end
    end
endmodule

// File: rtl/stmn_frame_gen.sv
// stmn_frame_gen: byte-serial STM-N framer mapping a VC4 payload stream into continuous frames
module stmn_frame_gen
  import stmn_frame_gen_pkg::*;
#(
  parameter int STM_N = 1,
  parameter int TRACE_LEN = 16,
  parameter int ENABLE_B1 = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic [7:0] in_data,
  input  logic in_valid,
  output logic in_ready,
  output logic [7:0] out_data,
  output logic out_valid,
  input  logic out_ready,
  output logic out_sof,
  output logic [15:0] frame_cnt,
  output logic underrun,
  output logic [15:0] underrun_cnt
);
  localparam logic [12:0] N13 = 13'(STM_N);
  stm_pos_t nxt;
  logic nxt_payload, wrap, xfer, starve;
  logic [3:0] trace_idx;
  logic [7:0] acc, b1_reg, nxt_byte;
  stmn_pos_cnt #(.STM_N(STM_N), .TRACE_LEN(TRACE_LEN)) u_pos (
    .clk(clk),
    .rst(rst),
    .advance(xfer),
    .nxt(nxt),
    .nxt_payload(nxt_payload),
    .wrap(wrap),
    .frame_cnt(frame_cnt),
    .trace_idx(trace_idx)
  );
  assign xfer = out_valid & out_ready;
  assign in_ready = xfer & nxt_payload;
  assign starve = in_ready & ~in_valid;
  assign nxt_byte = nxt_payload ? (in_valid ? in_data : 8'h00) :
                    oh_byte(nxt.row, nxt.col, N13, TRACE_MSG[trace_idx],
                            ENABLE_B1 != 0 ? b1_reg : 8'h00);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_data <= '0;
      out_valid <= 1'b0;
      out_sof <= 1'b0;
      underrun <= 1'b0;
      underrun_cnt <= '0;
      acc <= '0;
      b1_reg <= '0;
    end else if (!out_valid) begin
      out_data <= A1_BYTE;
      out_valid <= 1'b1;
      out_sof <= 1'b1;
    end else begin
      underrun <= starve;
      if (starve && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
      if (xfer) begin
        out_data <= nxt_byte;
        out_sof <= wrap;
        acc <= wrap ? 8'h00 : acc ^ out_data;
        if (wrap) b1_reg <= acc ^ out_data;
      end
    end
endmodule

// File: tb/tb_stmn_frame_gen.sv
// tb_stmn_frame_gen: scoreboard bench for the STM-N framer at N=1 with an N=4 side instance
module tb_stmn_frame_gen;
  localparam int N1 = 1;
  localparam int COLS = 270;
  localparam int FRAME = 2430;
  typedef struct {
    logic [7:0] data;
    logic sof;
    logic under;
  } exp_t;
  logic clk = 1'b0, rst = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, out_sof, underrun;
  logic [7:0] out_data;
  logic [15:0] frame_cnt, underrun_cnt;
  logic in_ready4, out_valid4, out_sof4, underrun4;
  logic [7:0] out_data4;
  logic [15:0] frame_cnt4, underrun_cnt4;
  int tests = 0, fails = 0;
  exp_t q[$];
  string msg = "PARMAN          ";
  int mrow, mcol, mframe, mtrace, munder, beat, drop_lo;
  logic [7:0] macc, mb1, cur, pay, pay_inc;
  logic cur_sof;
  bit phase_b = 1'b0, done4 = 1'b0;
  logic [7:0] first10 [10] = '{8'hF6, 8'hF6, 8'hF6, 8'h28, 8'h28, 8'h28, 8'h50, 8'h00, 8'h00, 8'h01};

  stmn_frame_gen #(.STM_N(1)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof),
    .frame_cnt(frame_cnt), .underrun(underrun), .underrun_cnt(underrun_cnt));

  stmn_frame_gen #(.STM_N(4)) dut4 (
    .clk(clk), .rst(rst), .in_data(8'hA5), .in_valid(1'b1), .in_ready(in_ready4),
    .out_data(out_data4), .out_valid(out_valid4), .out_ready(1'b1), .out_sof(out_sof4),
    .frame_cnt(frame_cnt4), .underrun(underrun4), .underrun_cnt(underrun_cnt4));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_byte(int n, int r, int c, logic [7:0] d, logic v,
                                          int tr, logic [7:0] b1);
    if (c >= 9 * n) return v ? d : 8'h00;
    if (r == 0) return c < 3 * n ? 8'hF6 : c < 6 * n ? 8'h28 : c == 6 * n ? msg[tr] : 8'h00;
    if (r == 1 && c == 0) return b1;
    if (r == 3) return c == 0 ? 8'h68 : c < n ? 8'h93 : (c > 3 * n && c < 4 * n) ? 8'hFF : 8'h00;
    return 8'h00;
  endfunction

  task automatic model_reset();
    mrow = 0; mcol = 0; mframe = 0; mtrace = 0; munder = 0; beat = 0;
    macc = 8'h00; mb1 = 8'h00; cur = 8'hF6; cur_sof = 1'b1;
    q.delete();
  endtask

  task automatic step(input logic r, input logic v);
    int nr, nc;
    logic pl, wr;
    exp_t e;
    @(negedge clk);
    out_ready = r; in_valid = v; in_data = pay;
    #1;
    wr = (mrow == 8 && mcol == COLS - 1);
    nc = (mcol == COLS - 1) ? 0 : mcol + 1;
    nr = wr ? 0 : (mcol == COLS - 1) ? mrow + 1 : mrow;
    pl = nc >= 9 * N1;
    check("in_ready", 16'(in_ready), 16'(r & pl));
    if (r) begin
      macc ^= cur;
      if (wr) begin
        mb1 = macc; macc = 8'h00; mframe++; mtrace = (mtrace + 1) % 16;
      end
      mrow = nr; mcol = nc; beat++;
      e.data = exp_byte(N1, nr, nc, pay, v, mtrace, mb1);
      e.sof = wr;
      e.under = pl & ~v;
      if (e.under && munder < 65535) munder++;
      if (pl && v) pay += pay_inc;
      q.push_back(e);
    end
    @(posedge clk); #1;
    if (r) begin
      e = q.pop_front();
      cur = e.data; cur_sof = e.sof;
    end else begin
      e.data = cur; e.sof = cur_sof; e.under = 1'b0;
    end
    check("out_data", 16'(out_data), 16'(e.data));
    check("out_sof", 16'(out_sof), 16'(e.sof));
    check("underrun", 16'(underrun), 16'(e.under));
    check("out_valid", 16'(out_valid), 16'd1);
    check("frame_cnt", frame_cnt, 16'(mframe));
    check("underrun_cnt", underrun_cnt, 16'(munder));
  endtask

  task automatic run_to(input int target);
    while (beat < target) step(1'b1, !((beat + 1) >= drop_lo && (beat + 1) < drop_lo + 5));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 16'(out_valid), 16'd0);
    check({tag, "_sof"}, 16'(out_sof), 16'd0);
    check({tag, "_data"}, 16'(out_data), 16'd0);
    check({tag, "_ready"}, 16'(in_ready), 16'd0);
    check({tag, "_frames"}, frame_cnt, 16'd0);
    check({tag, "_under"}, 16'(underrun), 16'd0);
    check({tag, "_ucnt"}, underrun_cnt, 16'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    out_ready = 1'b0;
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check("first_a1", 16'(out_data), 16'hF6);
    check("first_sof", 16'(out_sof), 16'd1);
    check("first_valid", 16'(out_valid), 16'd1);
    check("first_frames", frame_cnt, 16'd0);
  endtask

  initial begin
    pay = 8'h01; pay_inc = 8'h01;
    drop_lo = FRAME + 2 * COLS + 20;
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst0");
    release_reset();
    for (int i = 1; i < 10; i++) begin
      run_to(i);
      check("first_beats", 16'(out_data), 16'(first10[i]));
    end
    run_to(COLS);
    check("b1_frame0", 16'(out_data), 16'h00);
    run_to(drop_lo + 4);
    check("drop_under", 16'(underrun), 16'd1);
    check("drop_cnt", underrun_cnt, 16'd5);
    check("drop_data", 16'(out_data), 16'h00);
    run_to(2 * FRAME + 5 * COLS + 50);
    repeat (10) step(1'b0, 1'b1);
    run_to(3 * FRAME + 4 * COLS + 100);
    check("frames_before_rst", frame_cnt, 16'd3);
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_mid");
    phase_b = 1'b1;
    pay = 8'h00; pay_inc = 8'h00; drop_lo = -100;
    release_reset();
    run_to(6);
    check("j0_f0", 16'(out_data), 16'h50);
    run_to(COLS);
    check("b1_f0_rst", 16'(out_data), 16'h00);
    run_to(FRAME + 6);
    check("j0_f1", 16'(out_data), 16'h41);
    run_to(FRAME + COLS);
    check("b1_f1", 16'(out_data), 16'hE6);
    run_to(16 * FRAME);
    check("sof_f16", 16'(out_sof), 16'd1);
    run_to(16 * FRAME + 6);
    check("j0_f16", 16'(out_data), 16'h50);
    check("frames_f16", frame_cnt, 16'd16);
    wait (done4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    wait (phase_b);
    for (int k = 0; k <= 9720; k++) begin
      @(posedge clk); #2;
      check("n4_valid", 16'(out_valid4), 16'd1);
      check("n4_under", 16'(underrun4), 16'd0);
      if (k < 37)
        check("n4_row0", 16'(out_data4),
              16'(k < 12 ? 8'hF6 : k < 24 ? 8'h28 : k == 24 ? 8'h50 : k < 36 ? 8'h00 : 8'hA5));
      if (k >= 3240 && k < 3256)
        check("n4_row3", 16'(out_data4),
              16'(k == 3240 ? 8'h68 : k < 3244 ? 8'h93 : (k > 3252 && k < 3256) ? 8'hFF : 8'h00));
      if (k == 0 || k == 9719 || k == 9720) check("n4_sof", 16'(out_sof4), 16'(k != 9719));
      if (k == 0) check("n4_ready_oh", 16'(in_ready4), 16'd0);
      if (k == 35) check("n4_ready_pl", 16'(in_ready4), 16'd1);
      if (k == 9720) begin
        check("n4_frames", frame_cnt4, 16'd1);
        check("n4_ucnt", underrun_cnt4, 16'd0);
      end
    end
    done4 = 1'b1;
  end
endmodule

// File: doc/stmn_frame_gen.md
Name: stmn_frame_gen

Overview:
- Byte-serial STM-N frame generator, N = 1, 4 or 16; the parametrised successor of the fixed STM-1 framing constants.
- Takes a VC4 payload byte stream on a valid/ready interface and maps it into continuous STM-N frames.
- Inserts A1/A2 framing, a cycling J0 trace message, a BIP-8 B1 byte and fixed H1/H2 pointer bytes.
- Sits between the VC4 mapper and the line-side CSV/serialiser stage.

Parameters:
- STM_N, 1, STM level N (legal: 1, 4, 16); frame is 9 rows x 270*N columns.
- TRACE_LEN, 16, number of J0 trace bytes cycled; one byte per frame.
- ENABLE_B1, 1, 1 = insert computed BIP-8; 0 = B1 slot carries 0x00.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  8  VC4 payload byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  payload byte accepted when in_valid & in_ready.
- out_data  out  8  STM-N frame byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- out_sof  out  1  high with the first byte of every frame (row 0, col 0).
- frame_cnt  out  16  completed frames; wraps 0xFFFF -> 0.
- underrun  out  1  one-cycle pulse when a payload slot is filled with 0x00.
- underrun_cnt  out  16  saturating count of filler bytes.

Behaviour:
- Reset (async assert): all outputs and counters are 0, including in_ready, out_valid, out_sof and the B1 accumulator.
- First clk edge after reset release:
  - Load row 0 col 0 (A1 = 0xF6).
  - out_valid = 1, out_sof = 1.
- out_valid stays 1 until the next reset.
- Transfer on out_valid & out_ready. Each transfer advances (row, col) in row-major order and loads the next byte into the out_data register on the same edge (1-cycle registered output).
- Without a transfer, out_data, out_sof and the counters hold.
- Position wrap: col wraps 270N-1 -> 0 and row increments; row 8 col 270N-1 -> row 0 col 0.
  - On that wrap, frame_cnt increments and the trace index increments modulo TRACE_LEN.
- Overhead area (cols 0..9N-1):
  - Row 0: cols 0..3N-1 = 0xF6 (A1); cols 3N..6N-1 = 0x28 (A2); col 6N = TRACE[trace_idx] (J0); all other cols 0x00.
  - Row 1: col 0 = B1; all other cols 0x00.
  - Row 3: col 0 = 0x68 (H1: NDF 0110, SS 10, pointer 0); cols 1..N-1 = 0x93; col 3N = 0x00 (H2); cols 3N+1..4N-1 = 0xFF; all other cols 0x00.
  - All other overhead bytes are 0x00.
- Payload area (cols 9N..270N-1, every row): 261N bytes per row.
  - in_ready = out_valid & out_ready & (next position is payload), combinational.
  - Next slot is payload and in_valid = 1: load in_data.
  - Next slot is payload and in_valid = 0: load 0x00, pulse underrun, increment underrun_cnt (saturate at 0xFFFF).
  - Framing never stalls for missing payload.
- B1 (BIP-8):
  - The accumulator XORs every transferred byte, including the B1 byte itself.
  - On the frame-wrap transfer, b1_reg = acc ^ last byte, then acc clears.
  - b1_reg resets to 0x00, so frame 0 carries B1 = 0x00.
- Simultaneous underrun and frame wrap: both take effect on the same edge.
- Reset mid-frame aborts immediately; the frame restarts from A1 with trace_idx = 0.

Decomposition:
- param_pkg additions:
  - STMN_COLS_PER_N = 270, OH_COLS_PER_N = 9.
  - A1_BYTE = 0xF6, A2_BYTE = 0x28.
  - H1_FIRST = 0x68, H1_CONCAT = 0x93, H2_FIRST = 0x00, H2_CONCAT = 0xFF.
  - J0 trace array TRACE_MSG[16] = "PARMAN" + 10 x SPACE_letter, built from the existing letter constants.
  - typedef stm_pos_t {row[3:0], col[12:0]}.
- Sub-module stmn_pos_cnt: row/col/frame/trace-index counters, with advance input and next-position-is-payload output.

Test Plan:
1. N=1, out_ready=1, in_valid=1, payload 0x01,0x02,...: first beats F6 F6 F6 28 28 28 50 00 00, then 0x01 at beat 9; out_sof exactly every 2430 beats; in_ready low during cols 0..8 of every row.
2. N=1, payload all 0x00: frame 1 row 1 col 0 = 0xE6 (F6^28^50^68); frame 0 B1 = 0x00; J0 reads 0x50,0x41... per TRACE_MSG and returns to 0x50 in frame 16.
3. Drop in_valid for 5 consecutive payload slots: five 0x00 bytes, underrun high 5 cycles, underrun_cnt = 5, A1 position of the next frame unchanged.
4. Hold out_ready low 10 cycles mid-row: out_data/out_sof stable, in_ready = 0, no payload consumed; resumes with the next byte in order.
5. Assert rst at row 4 col 100 of frame 3: outputs go to 0 immediately; after release, F6 with out_sof, frame_cnt = 0, J0 = 0x50, B1 = 0x00.
6. N=4: 12 x F6, 12 x 28, J0 at col 24, first payload at col 36, H1 row 3 = 68 93 93 93, frame = 9720 beats.
